// File: rtl/hash160_pkg.sv
// Shared constants and types for the Hash160 front end (text loader and SHA-256 core).
package hash160_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_BYTES = 64;
  localparam int unsigned BLK_W     = NUM_BYTES * DATA_W;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES);

  localparam logic [DATA_W-1:0] START_BYTE = 8'hAA;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  typedef logic [31:0] sha_word_t;

endpackage

// File: rtl/text_loader.sv
// Frames the byte stream into 512-bit blocks for the SHA-256 core.
// Optional sticky overrun flag when built with TEXT_LOADER_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting for START_BYTE
// LOAD  | shifting in NUM_BYTES payload bytes, one per clock
// HOLD  | block valid, waiting for i_block_ready
module text_loader
  import hash160_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_text,
  input  logic              i_block_ready,
  output logic [BLK_W-1:0]  o_block,
  output logic              o_block_valid,
`ifdef TEXT_LOADER_OVERRUN_EN
  output logic              o_overrun,
`endif
  output logic              o_busy
);

  loader_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             is_start;

  assign is_start = (i_text == START_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      o_block       <= '0;
      o_block_valid <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_start) begin
            state  <= LOAD;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          // Every byte is payload here, including START_BYTE.
          o_block <= {o_block[BLK_W-DATA_W-1:0], i_text};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state         <= HOLD;
            o_block_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (i_block_ready) begin
            o_block_valid <= 1'b0;
            cnt           <= '0;
            // A start byte on the handshake edge opens the next block with no lost cycle.
            if (is_start) begin
              state <= LOAD;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          o_block_valid <= 1'b0;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEXT_LOADER_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun <= 1'b0;
    end else if (state == HOLD && is_start && !i_block_ready) begin
      o_overrun <= 1'b1;
    end
  end
`endif

endmodule
